// File: rtl/obi_sram_pkg.sv
// Shared types and helpers for the OBI-to-SRAM adapter.
// The byte-lane merge is used to build the write word of a read-modify-write.
package obi_sram_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_e;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned NBYTES    = WORD_BITS / 8;

    function automatic logic [WORD_BITS-1:0] byte_merge(
        input logic [WORD_BITS-1:0] old_w,
        input logic [WORD_BITS-1:0] new_w,
        input logic [NBYTES-1:0]    be
    );
        logic [WORD_BITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/obi_sram_adapter.sv
// OBI subordinate in front of one SRAM port: window decode, one-cycle read latency,
// and partial-byte writes done as read-modify-write over two cycles.
module obi_sram_adapter
    import obi_sram_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 14,
    parameter logic [31:0] BASEADDR  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    output logic                 rvalid_o,
    output logic [DATAWIDTH-1:0] rdata_o,
    output logic                 err_o,
    output logic [ADDRWIDTH-1:0] sram_addr_o,
    output logic                 sram_we_o,
    output logic [DATAWIDTH-1:0] sram_d_o,
    input  logic [DATAWIDTH-1:0] sram_q_i
);

    localparam logic [31:0] WIN_BYTES = 32'd4 << ADDRWIDTH;

    state_e                 state_q, state_d;
    logic                   rvalid_q, rvalid_d;
    logic                   err_q, err_d;
    logic                   rd_q, rd_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [NBYTES-1:0]      be_q, be_d;
    logic [DATAWIDTH-1:0]   wdata_q, wdata_d;

    logic [31:0]            offset;
    logic                   hit;
    logic [ADDRWIDTH-1:0]   word;
    logic                   accept;
    logic                   full_w;
    logic                   part_w;
    logic                   in_rmw;

    assign offset = addr_i - BASEADDR;
    assign hit    = offset < WIN_BYTES;
    assign word   = ADDRWIDTH'(offset >> 2);
    assign in_rmw = (state_q == RMW);

    assign gnt_o  = ~rst & ~in_rmw;
    assign accept = req_i & gnt_o;
    assign full_w = we_i & hit & (be_i == '1);
    assign part_w = we_i & hit & (be_i != '0) & (be_i != '1);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        // Every grant yields exactly one response next cycle; for a partial
        // write that response coincides with the RMW write cycle.
        rvalid_d = accept;
        err_d    = accept & ~hit;
        rd_d     = accept & hit & ~we_i;
        if (in_rmw) begin
            state_d = IDLE;
        end else if (accept && part_w) begin
            state_d = RMW;
            addr_d  = word;
            be_d    = be_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

    // Reset gates the write strobe so an in-flight RMW never lands.
    assign sram_we_o   = ~rst & (in_rmw | (accept & full_w));
    assign sram_addr_o = in_rmw ? addr_q : word;
    assign sram_d_o    = in_rmw ? byte_merge(sram_q_i, wdata_q, be_q) : wdata_i;

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rd_q ? sram_q_i : '0;

endmodule

// File: tb/tb_obi_sram_adapter.sv
// Bench for obi_sram_adapter: bench-side SRAM, shadow memory model with a
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_obi_sram_adapter;

    localparam int unsigned AW     = 14;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] WINB   = 32'd4 << AW;
    localparam int unsigned NWORDS = 1 << AW;

    logic          clk, rst;
    logic          req_i, gnt_o, we_i;
    logic [31:0]   addr_i, wdata_i;
    logic [3:0]    be_i;
    logic          rvalid_o, err_o, sram_we_o;
    logic [31:0]   rdata_o, sram_d_o, sram_q_i;
    logic [AW-1:0] sram_addr_o;

    // Bench-side SRAM (registered read, read-before-write) with a preload port.
    logic [31:0]   mem [NWORDS];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    int total = 0;
    int bad   = 0;
    int stalls = 0;

    obi_sram_adapter #(
        .DATAWIDTH(32),
        .ADDRWIDTH(AW),
        .BASEADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .sram_addr_o(sram_addr_o),
        .sram_we_o  (sram_we_o),
        .sram_d_o   (sram_d_o),
        .sram_q_i   (sram_q_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        sram_q_i <= mem[sram_addr_o];
        if (sram_we_o) mem[sram_addr_o] <= sram_d_o;
        if (pl_en)     mem[pl_addr]     <= pl_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]   ref_mem [NWORDS];
    bit            busy;
    logic [AW-1:0] p_word;
    logic [3:0]    p_be;
    logic [31:0]   p_wd;
    bit            exp_v, exp_err;
    logic [31:0]   exp_rd;
    bit            nv, nerr;
    logic [31:0]   nrd, off, mrg;
    logic [AW-1:0] wd;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_gnt", 32'(gnt_o), 32'd0);
            chk("rst_we", 32'(sram_we_o), 32'd0);
            chk("rst_rvalid", 32'(rvalid_o), 32'd0);
            busy  = 0;
            exp_v = 0;
            if (pl_en) ref_mem[pl_addr] = pl_data;
        end else begin
            chk("rvalid", 32'(rvalid_o), 32'(exp_v));
            if (exp_v) begin
                chk("err", 32'(err_o), 32'(exp_err));
                chk("rdata", rdata_o, exp_rd);
            end
            chk("gnt", 32'(gnt_o), 32'(!busy));
            nv = 0; nerr = 0; nrd = '0;
            off = addr_i - BASE;
            wd  = AW'(off >> 2);
            if (busy) begin
                for (int i = 0; i < 4; i++)
                    mrg[8*i +: 8] = p_be[i] ? p_wd[8*i +: 8] : ref_mem[p_word][8*i +: 8];
                chk("rmw_we", 32'(sram_we_o), 32'd1);
                chk("rmw_addr", 32'(sram_addr_o), 32'(p_word));
                chk("rmw_d", sram_d_o, mrg);
                ref_mem[p_word] = mrg;
                busy = 0;
            end else if (req_i) begin
                nv = 1;
                if (off >= WINB) begin
                    nerr = 1;
                    chk("miss_we", 32'(sram_we_o), 32'd0);
                end else if (!we_i) begin
                    nrd = ref_mem[wd];
                    chk("rd_we", 32'(sram_we_o), 32'd0);
                    chk("rd_addr", 32'(sram_addr_o), 32'(wd));
                end else if (be_i == 4'hF) begin
                    chk("wr_we", 32'(sram_we_o), 32'd1);
                    chk("wr_addr", 32'(sram_addr_o), 32'(wd));
                    chk("wr_d", sram_d_o, wdata_i);
                    ref_mem[wd] = wdata_i;
                end else if (be_i == 4'h0) begin
                    chk("be0_we", 32'(sram_we_o), 32'd0);
                end else begin
                    chk("prd_we", 32'(sram_we_o), 32'd0);
                    chk("prd_addr", 32'(sram_addr_o), 32'(wd));
                    busy   = 1;
                    p_word = wd;
                    p_be   = be_i;
                    p_wd   = wdata_i;
                end
            end else begin
                chk("idle_we", 32'(sram_we_o), 32'd0);
            end
            exp_v   = nv;
            exp_err = nerr;
            exp_rd  = nrd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int unsigned a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = AW'(a);
        pl_data = d;
        sync();
    endtask

    // Present a request and hold it until the edge at which it is granted.
    task automatic send(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        bit ok;
        int n;
        req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
        ok = 0;
        n  = 0;
        while (!ok && n < 8) begin
            @(negedge clk);
            ok = gnt_o;
            if (!ok) stalls++;
            sync();
            n++;
        end
        if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        send(a, 1'b0, 4'h0, 32'h0);
        req_i = 1'b0;
        @(negedge clk);
        chk(name, rdata_o, exp);
        chk({name, "_rvalid"}, 32'(rvalid_o), 32'd1);
        chk({name, "_err"}, 32'(err_o), 32'd0);
        sync();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] ra, rd;
    logic [3:0]  rb;
    logic        rw;

    initial begin
        rst = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(0, 32'h0123_4567);
        preload(8, 32'h1122_3344);
        preload(12, 32'h5A5A_5A5A);
        preload(16, 32'hCAFE_F00D);
        pl_en = 1'b0;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_gnt", 32'(gnt_o), 32'd1);
        chk("post_reset_rvalid", 32'(rvalid_o), 32'd0);
        sync();

        // full write then immediate read of the same word
        send(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        read_check("t2_rdata", 32'h10, 32'hDEAD_BEEF);

        // partial write: one-cycle grant gap, merged lanes
        send(32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD);
        req_i = 1'b0;
        @(negedge clk);
        chk("t3_gnt_low", 32'(gnt_o), 32'd0);
        chk("t3_rvalid", 32'(rvalid_o), 32'd1);
        sync();
        read_check("t3_rdata", 32'h20, 32'h11BB_33DD);

        // ten back-to-back reads with no stall
        stalls = 0;
        for (int i = 0; i < 10; i++) send(32'(i * 4), 1'b0, 4'h0, 32'h0);
        req_i = 1'b0;
        chk("t4_stalls", 32'(stalls), 32'd0);
        repeat (2) sync();

        // first out-of-window word, then a be=0 write
        send(BASE + WINB, 1'b1, 4'hF, 32'hFFFF_FFFF);
        req_i = 1'b0;
        @(negedge clk);
        chk("t5_rvalid", 32'(rvalid_o), 32'd1);
        chk("t5_err", 32'(err_o), 32'd1);
        chk("t5_rdata", rdata_o, 32'h0);
        sync();
        send(32'h30, 1'b1, 4'h0, 32'h1234_5678);
        req_i = 1'b0;
        @(negedge clk);
        chk("t5b_rvalid", 32'(rvalid_o), 32'd1);
        chk("t5b_err", 32'(err_o), 32'd0);
        sync();
        repeat (2) sync();
        chk("t5_mem0", mem[0], 32'h0123_4567);
        chk("t5_mem12", mem[12], 32'h5A5A_5A5A);

        // reset during the RMW cycle aborts the write
        send(32'h40, 1'b1, 4'b0011, 32'h1234_5678);
        req_i = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk("t6_rvalid", 32'(rvalid_o), 32'd0);
        chk("t6_we", 32'(sram_we_o), 32'd0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_gnt", 32'(gnt_o), 32'd1);
        chk("t6_mem", mem[16], 32'hCAFE_F00D);
        sync();
        read_check("t6_rdata", 32'h40, 32'hCAFE_F00D);

        // randomized traffic against the model
        repeat (400) begin
            if ($urandom_range(3) == 0) begin
                req_i = 1'b0;
                sync();
            end else begin
                case ($urandom_range(7))
                    0:       ra = BASE + WINB + (32'($urandom_range(255)) << 2);
                    1:       ra = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                    default: ra = BASE + (32'($urandom_range(63)) << 2) + 32'($urandom_range(3));
                endcase
                rw = 1'($urandom_range(1));
                case ($urandom_range(3))
                    0:       rb = 4'hF;
                    1:       rb = 4'h0;
                    default: rb = 4'($urandom_range(15));
                endcase
                rd = $urandom;
                send(ra, rw, rb, rd);
            end
        end
        req_i = 1'b0;
        repeat (3) sync();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
